// File: rtl/push_pop_unit.sv
// push_pop_unit: PUSH/POP of a 16-bit register pair through an 8-bit memory port.
// Define PUSHPOP_AF_EN to support the AF pair (pair 3); otherwise pair 3 completes with err.
`timescale 1ns/1ps

package push_pop_pkg;
  typedef logic [1:0] gp_r16_sel_t;
  typedef logic [7:0] flags_t;
endpackage

module push_pop_unit
  import push_pop_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_pop,
  input  logic [1:0]  cmd_pair,
  output gp_r16_sel_t r_sel16,
  input  logic [15:0] r16,
  input  logic [7:0]  r_a,
  input  flags_t      r_f,
  input  logic [15:0] r_sp,
  output logic        wen_gp16,
  output gp_r16_sel_t w_sel16,
  output logic [15:0] w16,
  output logic        wen_a,
  output logic [7:0]  w_a,
  output logic        wen_f,
  output logic [7:0]  w_f,
  output logic        wen_sp,
  output logic [15:0] w_sp,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, XFER0, XFER1, COMMIT} state_t;

  state_t      state;
  logic        pop_q, err_q;
  logic [1:0]  pair_q;
  logic [15:0] sp_q, data_q;
  logic        af_cmd, skip;
  logic        xfer, ok;

  assign af_cmd = (cmd_pair == 2'd3);
`ifdef PUSHPOP_AF_EN
  assign skip = 1'b0;
`else
  assign skip = af_cmd;
`endif

  // data_q holds the push operand, or assembles {hi, lo} as pop bytes arrive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pop_q  <= 1'b0;
      err_q  <= 1'b0;
      pair_q <= 2'd0;
      sp_q   <= 16'd0;
      data_q <= 16'd0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          pop_q  <= cmd_pop;
          pair_q <= cmd_pair;
          sp_q   <= r_sp;
          err_q  <= skip;
          data_q <= af_cmd ? {r_a, r_f} : r16;
          state  <= skip ? COMMIT : XFER0;
        end
        XFER0: if (mem_ack) begin
          if (pop_q) data_q[7:0] <= mem_rdata;
          state <= XFER1;
        end
        XFER1: if (mem_ack) begin
          if (pop_q) data_q[15:8] <= mem_rdata;
          state <= COMMIT;
        end
        COMMIT: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign xfer      = (state == XFER0) || (state == XFER1);
  assign ok        = (state == COMMIT) && !err_q;
  assign cmd_ready = (state == IDLE);
  assign r_sel16   = (state == IDLE) ? cmd_pair : pair_q;
  assign mem_req   = xfer;
  assign mem_we    = xfer && !pop_q;
  assign done      = (state == COMMIT);
  assign err       = (state == COMMIT) && err_q;

  always_comb begin
    mem_addr  = 16'd0;
    mem_wdata = 8'd0;
    case (state)
      XFER0: begin
        mem_addr  = pop_q ? sp_q : sp_q - 16'd1;
        mem_wdata = pop_q ? 8'd0 : data_q[15:8];
      end
      XFER1: begin
        mem_addr  = pop_q ? sp_q + 16'd1 : sp_q - 16'd2;
        mem_wdata = pop_q ? 8'd0 : data_q[7:0];
      end
      default: ;
    endcase
  end

  assign wen_sp   = ok;
  assign w_sp     = ok ? (pop_q ? sp_q + 16'd2 : sp_q - 16'd2) : 16'd0;
  assign wen_gp16 = ok && pop_q && (pair_q != 2'd3);
  assign w_sel16  = wen_gp16 ? pair_q : 2'd0;
  assign w16      = wen_gp16 ? data_q : 16'd0;
  assign wen_a    = ok && pop_q && (pair_q == 2'd3);
  assign wen_f    = wen_a;
  assign w_a      = wen_a ? data_q[15:8] : 8'd0;
  assign w_f      = wen_f ? (data_q[7:0] & 8'hF0) : 8'd0;

endmodule

// File: tb/tb_push_pop_unit.sv
// Bench for push_pop_unit: environment register file + memory, random and directed commands
// checked against a byte/register model of PUSH/POP semantics.
`timescale 1ns/1ps

module tb_push_pop_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_pop = 1'b0;
  logic [1:0]  cmd_pair = 2'd0;
  logic        cmd_ready;
  logic [1:0]  r_sel16, w_sel16;
  logic [15:0] r16, r_sp, w16, w_sp;
  logic [7:0]  r_a, r_f, w_a, w_f;
  logic        wen_gp16, wen_a, wen_f, wen_sp;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        done, err;

  push_pop_unit dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pop(cmd_pop), .cmd_pair(cmd_pair), .r_sel16(r_sel16), .r16(r16),
    .r_a(r_a), .r_f(r_f), .r_sp(r_sp), .wen_gp16(wen_gp16), .w_sel16(w_sel16),
    .w16(w16), .wen_a(wen_a), .w_a(w_a), .wen_f(wen_f), .w_f(w_f),
    .wen_sp(wen_sp), .w_sp(w_sp), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .done(done), .err(err)
  );

  // environment register file, written by the DUT or preloaded by the bench
  logic [15:0] rf_bc, rf_de, rf_hl, rf_sp;
  logic [7:0]  rf_a, rf_f;
  logic        pre_en = 1'b0;
  logic [15:0] pre_bc = 16'd0, pre_de = 16'd0, pre_hl = 16'd0, pre_sp = 16'd0;
  logic [7:0]  pre_a = 8'd0, pre_f = 8'd0;

  always @(posedge clk) begin
    if (pre_en) begin
      rf_bc <= pre_bc; rf_de <= pre_de; rf_hl <= pre_hl;
      rf_sp <= pre_sp; rf_a <= pre_a; rf_f <= pre_f;
    end else begin
      if (wen_sp) rf_sp <= w_sp;
      if (wen_gp16)
        case (w_sel16)
          2'd0: rf_bc <= w16;
          2'd1: rf_de <= w16;
          2'd2: rf_hl <= w16;
          default: ;
        endcase
      if (wen_a) rf_a <= w_a;
      if (wen_f) rf_f <= w_f;
    end
  end

  assign r16  = (r_sel16 == 2'd0) ? rf_bc : (r_sel16 == 2'd1) ? rf_de : rf_hl;
  assign r_a  = rf_a;
  assign r_f  = rf_f;
  assign r_sp = rf_sp;

  // memory with programmable ack delay; spur injects an ack with no request
  logic [7:0]  mem [0:65535];
  int          ack_dly = 0, wcnt = 0;
  logic        spur = 1'b0;
  logic        pk_en = 1'b0;
  logic [15:0] pk_addr = 16'd0;
  logic [7:0]  pk_data = 8'd0;

  assign mem_ack   = spur || (mem_req && (wcnt >= ack_dly));
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  int n_done = 0;
  always @(posedge clk) if (done) n_done <= n_done + 1;

  // reference model
  logic [15:0] m_bc, m_de, m_hl, m_sp;
  logic [7:0]  m_a, m_f;
  logic [7:0]  mm [logic [15:0]];
  int tests = 0, fails = 0, accepted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_regs(input logic [15:0] bc, de, hl, sp, input logic [7:0] a, f);
    @(negedge clk);
    pre_bc = bc; pre_de = de; pre_hl = hl; pre_sp = sp; pre_a = a; pre_f = f;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    m_bc = bc; m_de = de; m_hl = hl; m_sp = sp; m_a = a; m_f = f;
  endtask

  task automatic poke(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    pk_en = 1'b1; pk_addr = addr; pk_data = data;
    @(negedge clk);
    pk_en = 1'b0;
    mm[addr] = data;
  endtask

  task automatic run_cmd(input bit pop, input logic [1:0] pair, input int dly, input bit hold);
    logic [15:0] sp0, opnd, a0, a1, val, prev_addr;
    logic [15:0] qa[$];
    int lat, nreq, nwen;
    bit got_done, prev_wait, skip;
`ifdef PUSHPOP_AF_EN
    skip = 1'b0;
`else
    skip = (pair == 2'd3);
`endif
    sp0  = m_sp;
    opnd = (pair == 2'd0) ? m_bc : (pair == 2'd1) ? m_de : (pair == 2'd2) ? m_hl : {m_a, m_f};
    a0   = pop ? sp0 : sp0 - 16'd1;
    a1   = pop ? sp0 + 16'd1 : sp0 - 16'd2;
    ack_dly = dly;
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_pop = pop; cmd_pair = pair;
    accepted++;
    @(posedge clk);
    lat = 0; nreq = 0; nwen = 0; got_done = 0; prev_wait = 0; prev_addr = 16'd0;
    while (!got_done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (hold) begin
        cmd_pop = 1'($urandom); cmd_pair = 2'($urandom);
      end else cmd_valid = 1'b0;
      if (lat == 1) chk("busy_not_ready", cmd_ready, 0);
      if (mem_req) begin
        nreq++;
        if (prev_wait) chk("addr_stable", mem_addr, prev_addr);
        if (mem_ack) qa.push_back(mem_addr);
        prev_wait = !mem_ack; prev_addr = mem_addr;
      end else prev_wait = 0;
      if (!done && (wen_sp || wen_gp16 || wen_a || wen_f)) nwen++;
      if (done) begin
        got_done = 1;
        chk("err", err, skip);
      end
    end
    cmd_valid = 1'b0;
    chk("done_seen", got_done, 1);
    chk("done_latency", lat, skip ? 1 : 2 * dly + 3);
    chk("mem_req_cycles", nreq, skip ? 0 : 2 * dly + 2);
    chk("wen_outside_commit", nwen, 0);
    chk("n_acks", qa.size(), skip ? 0 : 2);
    if (qa.size() == 2) begin
      chk("addr_xfer0", qa[0], a0);
      chk("addr_xfer1", qa[1], a1);
    end
    if (!skip) begin
      if (pop) begin
        val = {mm[a1], mm[a0]};
        case (pair)
          2'd0: m_bc = val;
          2'd1: m_de = val;
          2'd2: m_hl = val;
          default: begin m_a = val[15:8]; m_f = val[7:0] & 8'hF0; end
        endcase
        m_sp = sp0 + 16'd2;
      end else begin
        mm[a0] = opnd[15:8];
        mm[a1] = opnd[7:0];
        m_sp = sp0 - 16'd2;
      end
    end
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("ready_after", cmd_ready, 1);
    chk("rf_sp", rf_sp, m_sp);
    chk("rf_bc", rf_bc, m_bc);
    chk("rf_de", rf_de, m_de);
    chk("rf_hl", rf_hl, m_hl);
    chk("rf_a", rf_a, m_a);
    chk("rf_f", rf_f, m_f);
    if (!skip && !pop) begin
      chk("mem_hi", mem[a0], opnd[15:8]);
      chk("mem_lo", mem[a1], opnd[7:0]);
    end
  endtask

  initial begin
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wen_sp", wen_sp, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    // PUSH DE at top of stack, zero-wait
    set_regs(16'h1111, 16'h1234, 16'h3333, 16'hFFFE, 8'h44, 8'h55);
    run_cmd(1'b0, 2'd1, 0, 1'b0);
    chk("push_de_hi", mem[16'hFFFD], 8'h12);
    chk("push_de_lo", mem[16'hFFFC], 8'h34);
    chk("push_de_sp", rf_sp, 16'hFFFC);

    // POP HL across the address wrap, two wait states per byte
    set_regs(16'h1111, 16'h2222, 16'h0000, 16'hFFFF, 8'h44, 8'h55);
    poke(16'hFFFF, 8'hCD);
    poke(16'h0000, 8'hAB);
    run_cmd(1'b1, 2'd2, 2, 1'b0);
    chk("pop_hl_val", rf_hl, 16'hABCD);
    chk("pop_hl_sp", rf_sp, 16'h0001);

    // POP AF: flag low nibble is forced to zero
    set_regs(16'h1111, 16'h2222, 16'h3333, 16'h4000, 8'h00, 8'h00);
    poke(16'h4000, 8'hFF);
    poke(16'h4001, 8'h5A);
    run_cmd(1'b1, 2'd3, 0, 1'b0);
`ifdef PUSHPOP_AF_EN
    chk("pop_af_a", rf_a, 8'h5A);
    chk("pop_af_f", rf_f, 8'hF0);
`else
    chk("pop_af_sp_kept", rf_sp, 16'h4000);
`endif

    // spurious acks while idle must not start anything
    @(negedge clk);
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_ready", cmd_ready, 1);
      chk("spur_mem_req", mem_req, 0);
      chk("spur_done", done, 0);
    end
    spur = 1'b0;

    // cmd_valid held (with changing fields) throughout a busy command
    run_cmd(1'b0, 2'd0, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      bit rp;
      logic [1:0] rpair;
      if ($urandom_range(0, 3) == 0)
        set_regs(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 8'($urandom), 8'($urandom));
      rp    = 1'($urandom);
      rpair = 2'($urandom);
      if (rp) begin
        poke(m_sp, 8'($urandom));
        poke(m_sp + 16'd1, 8'($urandom));
      end
      run_cmd(rp, rpair, $urandom_range(0, 3), 1'($urandom));
    end

    // reset during the second transfer of PUSH BC
    set_regs(16'hBEEF, 16'h2222, 16'h3333, 16'h8000, 8'h44, 8'h55);
    ack_dly = 2;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_pop = 1'b0; cmd_pair = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_addr", mem_addr, 16'h7FFE);
    chk("rst_mid_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", mem_req, 0);
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_wen_sp", wen_sp, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_addr0", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    chk("rst_mid_sp_kept", rf_sp, 16'h8000);
    chk("rst_mid_mem_lo_untouched", mem[16'h7FFE] === 8'hEF, 0);
    chk("done_count", n_done, accepted);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
